// File: rtl/mips_lsu.sv
// Load/store unit for the multicycle MIPS core.
// The core issues one request at a time. This unit sends it to data memory
// over the Address/MemRead/MemWrite channel, extracts and extends load data,
// and holds the response in a register until the core accepts it. Misaligned
// or unsupported sizes are answered with an error and never reach memory.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; latch fields and check for errors
// REQ    | memory request driven, waiting for Mem_Req_Ack
// RDW    | load issued, waiting for Read_data_Valid
// RESP   | response presented, waiting for resp_ready
module mips_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemWrite,
    output logic [DATA_W-1:0]   Write_data,
    output logic [DATA_W/8-1:0] Write_strb,
    output logic                MemRead,
    input  logic                Mem_Req_Ack,
    input  logic [DATA_W-1:0]   Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ack,
    output logic [CNT_W-1:0]    perf_req_cnt,
    output logic [CNT_W-1:0]    perf_wait_cnt,
    output logic [CNT_W-1:0]    perf_err_cnt
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_REQ  = 4'b0010,
        S_RDW  = 4'b0100,
        S_RESP = 4'b1000
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic              sgn_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [OW-1:0]     off_q;

    logic              accept;
    logic              req_err;
    logic [2:0]        align_mask;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] ld_ext;
    logic              sign_bit;
    logic [NB-1:0]     lane_strb;
    logic              wait_inc;

    function automatic int size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    assign accept = (state_q == S_IDLE) && req_valid;
    assign off_q  = addr_q[OW-1:0];

    // Error check on the incoming request: size wider than the bus or address not size-aligned
    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        req_err = ({1'b0, req_size} > 3'(OW)) || (|(req_addr[2:0] & align_mask));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid)       state_d = req_err ? S_RESP : S_REQ;
            S_REQ:  if (Mem_Req_Ack)     state_d = we_q ? S_RESP : S_RDW;
            S_RDW:  if (Read_data_Valid) state_d = S_RESP;
            S_RESP: if (resp_ready)      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Byte-lane enables covering 2^size bytes starting at the latched offset
    always_comb begin
        lane_strb = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(off_q) && i < int'(off_q) + size_bytes(size_q))
                lane_strb[i] = 1'b1;
        end
    end

    // Outputs, decoded from registered state and latched request fields
    always_comb begin
        req_ready     = (state_q == S_IDLE);
        resp_valid    = (state_q == S_RESP);
        Read_data_Ack = (state_q == S_RDW);
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        Address       = '0;
        Write_strb    = '0;
        Write_data    = '0;
        if (state_q == S_REQ) begin
            MemWrite = we_q;
            MemRead  = !we_q;
            Address  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
            if (we_q) begin
                Write_strb = lane_strb;
                Write_data = wdata_q << {off_q, 3'b000};
            end
        end
    end

    // Load data: right-justify the addressed bytes, then sign- or zero-extend
    always_comb begin
        rd_shift = Read_data >> {off_q, 3'b000};
        case (size_q)
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[DATA_W-1];
        endcase
        ld_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ld_ext[i] = (i < 8 * size_bytes(size_q)) ? rd_shift[i] : (sgn_q & sign_bit);
        end
    end

    // Request field latch and registered response buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            err_q   <= req_err;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (state_q == S_RDW && Read_data_Valid) begin
            rdata_q <= ld_ext;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign wait_inc = ((state_q == S_REQ) && !Mem_Req_Ack) ||
                      ((state_q == S_RDW) && !Read_data_Valid);

    // Performance counters; errors are counted on the IDLE->RESP transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_cnt  <= '0;
            perf_wait_cnt <= '0;
            perf_err_cnt  <= '0;
        end else begin
            if (accept)            perf_req_cnt  <= perf_req_cnt + CNT_W'(1);
            if (wait_inc)          perf_wait_cnt <= perf_wait_cnt + CNT_W'(1);
            if (accept && req_err) perf_err_cnt  <= perf_err_cnt + CNT_W'(1);
        end
    end

endmodule
